btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Controller that sequences the 32-entry branch target buffer and owns its 2-bit direction counters.
- On the fetch side, it combines the BTB lookup result with the counter state to produce `next_pc`.
- On the EX side, it detects mispredictions and queues resolved branches.
- It drains that queue into the single shared BTB write port, and performs a 32-cycle invalidate sweep after every reset.

Parameters:
- INDEX_BITS, 5, BTB index width; the table has 2**INDEX_BITS entries; the index is taken from pc[INDEX_BITS+1:2].
- DEPTH, 4, update-queue depth in entries (power of two, at least 2).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears state).
- current_pc  in  32  fetch PC.
- btb_tag_match  in  1  BTB hit for current_pc.
- btb_target  in  32  BTB target for current_pc.
- pred_taken  out  1  fetch prediction.
- next_pc  out  32  predicted next fetch PC.
- ex_valid  in  1  resolved branch present in EX.
- ex_pc  in  32  PC of the resolved branch.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  flush request.
- redirect_pc  out  32  correct PC on mispredict.
- btb_wr_en  out  1  BTB write strobe.
- btb_wr_index  out  INDEX_BITS  BTB write index.
- btb_wr_pc  out  32  source PC written (the BTB derives the tag from it).
- btb_wr_target  out  32  target written.
- btb_wr_valid  out  1  valid bit written.
- btb_wr_grant  in  1  the shared write port accepts this cycle.
- init_busy  out  1  invalidate sweep in progress.
- upd_full  out  1  queue full; EX must stall.
- upd_ovf  out  1  sticky overflow flag.

Behaviour:
- **Clock and reset:** one clock; reset is synchronous and active-low.
- **Reset state:**
  - FSM = INIT, sweep index = 0.
  - Queue empty, upd_ovf = 0.
  - All counters = 2'b01 (weakly not-taken).
- **Output values during reset and INIT:** pred_taken = 0; next_pc = current_pc+4; btb_wr_en = 0 in the reset cycle.
- **Reset mid-operation:** discards the queue and restarts the sweep at index 0.
- **FSM INIT:**
  - init_busy = 1.
  - Each cycle drives btb_wr_en = 1, btb_wr_valid = 0, btb_wr_index = sweep index, btb_wr_pc = 0, btb_wr_target = 0.
  - The sweep index advances only when btb_wr_grant = 1.
  - After a granted write at index 2**INDEX_BITS-1, go to RUN.
  - ex_valid is ignored; nothing is pushed.
- **FSM RUN:** init_busy = 0. No path back to INIT except reset.
- **Prediction (combinational, RUN only):**
  - pred_taken = btb_tag_match & counter[idx(current_pc)][1].
  - next_pc = pred_taken ? btb_target : current_pc+4 (32-bit wrap).
- **Mispredict (combinational, any state):**
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, driven whenever ex_valid.
- **Queue push:**
  - In RUN, ex_valid pushes {ex_pc, ex_taken, ex_target} at the posedge.
  - The entry becomes visible at the head the following cycle (1-cycle latency).
- **Queue drain:**
  - The head is examined every cycle when the queue is non-empty.
  - If head.taken: drive btb_wr_en = 1, btb_wr_valid = 1, index = idx(head.pc), btb_wr_pc = head.pc, btb_wr_target = head.target. Pop and update the counter only when btb_wr_grant = 1; otherwise hold all outputs stable.
  - If head not taken: btb_wr_en = 0; pop and decrement the counter unconditionally that cycle.
- **Counter update:**
  - 2-bit saturating: increment toward 3 on taken, decrement toward 0 on not-taken.
  - Applied at the posedge of the pop.
  - A same-cycle fetch lookup of that index sees the old value.
- **Simultaneous push and pop:** allowed; count is unchanged and the order is preserved.
- **Full and overflow:**
  - upd_full = (count == DEPTH), combinational from registered count.
  - ex_valid while full with no pop that cycle: the entry is dropped and upd_ovf sets (cleared only by reset).
  - A push while full with a pop in the same cycle is accepted.
- **Wrap-around:** read and write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Test Plan:
- **Reset and sweep:** reset=0 for 2 cycles, then 1 with btb_wr_grant=1 → 32 cycles of btb_wr_en=1, valid=0, index 0..31, init_busy=1, pred_taken=0; RUN on cycle 33.
- **Prediction hit:**
  - Setup: after four taken updates for pc 0x0000_0040 → target 0x0000_0100, lookup with current_pc=0x40, btb_tag_match=1, btb_target=0x100 → pred_taken=1, next_pc=0x100.
  - Same lookup with btb_tag_match=0 → next_pc=0x44.
- **Mispredict:**
  - ex_valid, ex_pc=0x80, ex_taken=1, ex_target=0x200, ex_pred_taken=0 → mispredict=1, redirect_pc=0x200.
  - ex_taken=0, ex_pred_taken=1 → redirect_pc=0x84.
  - Both taken, targets 0x200 vs 0x204 → mispredict=1.
- **Grant backpressure:** btb_wr_grant=0 while pushing 4 taken branches → upd_full=1 and the head outputs stay constant; a 5th ex_valid sets upd_ovf=1; raising the grant drains 4 writes in order, one per cycle.
- **Counter saturation:** five not-taken resolutions at pc 0x40 → counter=0, no BTB writes issued, pred_taken=0 even with a hit; then two taken → counter=2, prediction taken.
- **Reset mid-drain:** 3 entries queued with grant=0, then reset=0 for 1 cycle → queue empty, upd_full=0, upd_ovf=0, sweep restarts at index 0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// BTB sequencing controller: fetch-side prediction, EX-side mispredict detection,
// resolved-branch update queue draining into the shared BTB write port, post-reset invalidate sweep.
module btb_update_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           current_pc,
  input  logic                  btb_tag_match,
  input  logic [31:0]           btb_target,
  output logic                  pred_taken,
  output logic [31:0]           next_pc,
  input  logic                  ex_valid,
  input  logic [31:0]           ex_pc,
  input  logic                  ex_taken,
  input  logic [31:0]           ex_target,
  input  logic                  ex_pred_taken,
  input  logic [31:0]           ex_pred_target,
  output logic                  mispredict,
  output logic [31:0]           redirect_pc,
  output logic                  btb_wr_en,
  output logic [INDEX_BITS-1:0] btb_wr_index,
  output logic [31:0]           btb_wr_pc,
  output logic [31:0]           btb_wr_target,
  output logic                  btb_wr_valid,
  input  logic                  btb_wr_grant,
  output logic                  init_busy,
  output logic                  upd_full,
  output logic                  upd_ovf
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PW      = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  typedef enum logic {INIT, RUN} state_t;

  state_t                    state, state_nxt;
  logic [INDEX_BITS-1:0]     sweep_idx;
  logic [ENTRIES-1:0][1:0]   ctr;
  upd_t [DEPTH-1:0]          q;
  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [PW:0]               count;
  upd_t                      head;
  logic                      q_empty, pop, push_req, push;
  logic [INDEX_BITS-1:0]     head_idx;
  logic [1:0]                lookup_ctr, head_ctr;

  assign head       = q[rd_ptr];
  assign head_idx   = head.pc[INDEX_BITS+1:2];
  assign head_ctr   = ctr[head_idx];
  assign q_empty    = (count == '0);
  assign upd_full   = (count == (PW+1)'(DEPTH));
  assign init_busy  = (state == INIT);
  assign push       = push_req & (~upd_full | pop);

  // Prediction is suppressed while the table is being invalidated or held in reset.
  assign lookup_ctr = ctr[current_pc[INDEX_BITS+1:2]];
  assign pred_taken = reset & (state == RUN) & btb_tag_match & lookup_ctr[1];
  assign next_pc    = pred_taken ? btb_target : current_pc + 32'd4;

  assign mispredict  = ex_valid & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
  assign redirect_pc = ex_valid ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'd0;

  always_comb begin
    state_nxt     = state;
    btb_wr_en     = 1'b0;
    btb_wr_valid  = 1'b0;
    btb_wr_index  = '0;
    btb_wr_pc     = 32'd0;
    btb_wr_target = 32'd0;
    pop           = 1'b0;
    push_req      = 1'b0;
    case (state)
      INIT: begin
        btb_wr_en    = 1'b1;
        btb_wr_index = sweep_idx;
        if (btb_wr_grant && sweep_idx == {INDEX_BITS{1'b1}}) state_nxt = RUN;
      end
      RUN: begin
        push_req = ex_valid;
        if (!q_empty) begin
          if (head.taken) begin
            btb_wr_en     = 1'b1;
            btb_wr_valid  = 1'b1;
            btb_wr_index  = head_idx;
            btb_wr_pc     = head.pc;
            btb_wr_target = head.target;
            pop           = btb_wr_grant;
          end else begin
            // Not-taken resolutions only train the counter; no BTB write needed.
            pop = 1'b1;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
    if (!reset) btb_wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INIT;
      sweep_idx <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      upd_ovf   <= 1'b0;
      ctr       <= {ENTRIES{2'b01}};
    end else begin
      state <= state_nxt;
      if (state == INIT && btb_wr_grant) sweep_idx <= sweep_idx + 1'b1;
      if (push) begin
        q[wr_ptr] <= '{pc: ex_pc, taken: ex_taken, target: ex_target};
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push_req && !push) upd_ovf <= 1'b1;
      if (pop) begin
        if (head.taken && head_ctr != 2'b11)      ctr[head_idx] <= head_ctr + 2'b01;
        else if (!head.taken && head_ctr != 2'b00) ctr[head_idx] <= head_ctr - 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a queue-based reference model tracks expected
// BTB writes, counters and flags; a negedge monitor compares every DUT output.
module tb_btb_update_ctrl;
  localparam int IB    = 5;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IB;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   current_pc, btb_target, ex_pc, ex_target, ex_pred_target;
  logic          btb_tag_match, ex_valid, ex_taken, ex_pred_taken, btb_wr_grant;
  logic          pred_taken, mispredict, btb_wr_en, btb_wr_valid, init_busy, upd_full, upd_ovf;
  logic [31:0]   next_pc, redirect_pc, btb_wr_pc, btb_wr_target;
  logic [IB-1:0] btb_wr_index;

  btb_update_ctrl #(.INDEX_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .current_pc(current_pc), .btb_tag_match(btb_tag_match),
    .btb_target(btb_target), .pred_taken(pred_taken), .next_pc(next_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .btb_wr_en(btb_wr_en),
    .btb_wr_index(btb_wr_index), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .btb_wr_valid(btb_wr_valid), .btb_wr_grant(btb_wr_grant), .init_busy(init_busy),
    .upd_full(upd_full), .upd_ovf(upd_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
  } ent_t;

  ent_t mq[$];
  bit   m_init = 1'b1;
  int   m_sweep = 0;
  bit   m_ovf = 1'b0;
  int   m_ctr[NENT];
  int   checks = 0;
  int   failures = 0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial foreach (m_ctr[i]) m_ctr[i] = 1;

  // Monitor + reference model: compare outputs mid-cycle, then advance the model
  // to the state the upcoming posedge will produce.
  always @(negedge clk) begin
    bit          exp_pred, exp_mis, exp_wr, popped;
    logic [31:0] exp_wpc, exp_wtgt;
    int          exp_widx, hi;
    bit          exp_wvalid;

    exp_pred = reset && !m_init && btb_tag_match && (m_ctr[idx_of(current_pc)] >= 2);
    chk("init_busy", 32'(init_busy), 32'(m_init));
    chk("upd_full", 32'(upd_full), 32'(mq.size() == DEPTH));
    chk("upd_ovf", 32'(upd_ovf), 32'(m_ovf));
    chk("pred_taken", 32'(pred_taken), 32'(exp_pred));
    chk("next_pc", next_pc, exp_pred ? btb_target : current_pc + 32'd4);
    exp_mis = ex_valid && ((ex_taken != ex_pred_taken) ||
                           (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
    chk("mispredict", 32'(mispredict), 32'(exp_mis));
    if (ex_valid) chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);

    exp_wr = 1'b0; exp_widx = 0; exp_wpc = 0; exp_wtgt = 0; exp_wvalid = 1'b0;
    if (reset) begin
      if (m_init) begin
        exp_wr = 1'b1; exp_widx = m_sweep;
      end else if (mq.size() > 0 && mq[0].taken) begin
        exp_wr = 1'b1; exp_widx = idx_of(mq[0].pc); exp_wpc = mq[0].pc;
        exp_wtgt = mq[0].target; exp_wvalid = 1'b1;
      end
    end
    chk("btb_wr_en", 32'(btb_wr_en), 32'(exp_wr));
    if (exp_wr && btb_wr_en) begin
      chk("btb_wr_index", 32'(btb_wr_index), 32'(exp_widx));
      chk("btb_wr_pc", btb_wr_pc, exp_wpc);
      chk("btb_wr_target", btb_wr_target, exp_wtgt);
      chk("btb_wr_valid", 32'(btb_wr_valid), 32'(exp_wvalid));
    end

    if (!reset) begin
      m_init = 1'b1; m_sweep = 0; m_ovf = 1'b0; mq.delete();
      foreach (m_ctr[i]) m_ctr[i] = 1;
    end else if (m_init) begin
      if (btb_wr_grant) begin
        m_sweep++;
        if (m_sweep == NENT) m_init = 1'b0;
      end
    end else begin
      popped = 1'b0;
      if (mq.size() > 0) begin
        hi = idx_of(mq[0].pc);
        if (!mq[0].taken) begin
          if (m_ctr[hi] > 0) m_ctr[hi]--;
          popped = 1'b1;
        end else if (btb_wr_grant) begin
          if (m_ctr[hi] < 3) m_ctr[hi]++;
          popped = 1'b1;
        end
        if (popped) void'(mq.pop_front());
      end
      if (ex_valid) begin
        if (mq.size() < DEPTH) mq.push_back('{pc: ex_pc, taken: ex_taken, target: ex_target});
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_drive(bit v, logic [31:0] pc, bit tk, logic [31:0] tgt);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = tk; ex_pred_target = tgt;
  endtask

  initial begin
    int n;
    logic [31:0] pcs[4];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h80; pcs[3] = 32'h3c0;
    reset = 1'b0; btb_wr_grant = 1'b1; current_pc = 32'h1000; btb_tag_match = 1'b0;
    btb_target = 32'h0; ex_drive(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset and full invalidate sweep
    step(); step();
    reset = 1'b1;
    repeat (31) step();
    chk("sweep_busy_c32", 32'(init_busy), 32'd1);
    step();
    chk("sweep_done_c33", 32'(init_busy), 32'd0);

    // Train pc 0x40 strongly taken, then look it up
    ex_drive(1'b1, 32'h40, 1'b1, 32'h100);
    repeat (4) step();
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) step();
    current_pc = 32'h40; btb_tag_match = 1'b1; btb_target = 32'h100; #1;
    chk("hit_pred", 32'(pred_taken), 32'd1);
    chk("hit_next_pc", next_pc, 32'h100);
    btb_tag_match = 1'b0; #1;
    chk("miss_next_pc", next_pc, 32'h44);
    step();

    // Mispredict cases (combinational only, nothing pushed)
    ex_valid = 1'b1; ex_pc = 32'h80; ex_taken = 1'b1; ex_target = 32'h200;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0; #1;
    chk("mis_tk", 32'(mispredict), 32'd1);
    chk("redir_tk", redirect_pc, 32'h200);
    ex_taken = 1'b0; ex_pred_taken = 1'b1; #1;
    chk("redir_nt", redirect_pc, 32'h84);
    ex_taken = 1'b1; ex_pred_taken = 1'b1; ex_pred_target = 32'h204; #1;
    chk("mis_tgt", 32'(mispredict), 32'd1);
    ex_valid = 1'b0;
    step();

    // Grant backpressure, overflow, in-order drain
    btb_wr_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_drive(1'b1, 32'h10 + 32'(4 * i), 1'b1, 32'h500 + 32'(i));
      step();
    end
    chk("bp_full", 32'(upd_full), 32'd1);
    ex_drive(1'b1, 32'h20, 1'b1, 32'h600);
    step();
    chk("bp_ovf", 32'(upd_ovf), 32'd1);
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) step();
    btb_wr_grant = 1'b1;
    repeat (4) step();
    chk("bp_drained", 32'(btb_wr_en), 32'd0);

    // Counter saturation at zero, then retrain
    ex_drive(1'b1, 32'h40, 1'b0, 32'h0);
    repeat (5) step();
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) step();
    current_pc = 32'h40; btb_tag_match = 1'b1; btb_target = 32'h100; #1;
    chk("sat0_pred", 32'(pred_taken), 32'd0);
    ex_drive(1'b1, 32'h40, 1'b1, 32'h100);
    repeat (2) step();
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    chk("retrain_pred", 32'(pred_taken), 32'd1);

    // Reset mid-drain
    btb_wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 32'h700);
      step();
    end
    ex_drive(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1; #1;
    chk("mid_full", 32'(upd_full), 32'd0);
    chk("mid_ovf", 32'(upd_ovf), 32'd0);
    chk("mid_busy", 32'(init_busy), 32'd1);
    chk("mid_idx0", 32'(btb_wr_index), 32'd0);
    n = 0;
    while (init_busy && n < 500) begin
      btb_wr_grant = ($urandom_range(0, 2) != 0);
      step(); n++;
    end
    chk("mid_sweep_bound", 32'(init_busy), 32'd0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 2500; c++) begin
      btb_wr_grant  = ($urandom_range(0, 3) != 0);
      btb_tag_match = $urandom_range(0, 1);
      btb_target    = $urandom;
      current_pc    = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      ex_valid      = $urandom_range(0, 1);
      ex_pc         = ($urandom_range(0, 4) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      ex_taken      = $urandom_range(0, 1);
      ex_target     = $urandom_range(0, 3) << 4;
      ex_pred_taken = $urandom_range(0, 1);
      ex_pred_target = $urandom_range(0, 3) << 4;
      reset         = ($urandom_range(0, 399) != 0);
      step();
    end
    reset = 1'b1;
    ex_valid = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
